// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses 0xA5-framed read/write commands from a UART RX byte
// stream, issues one 32-bit bus request per frame, and streams an ACK (0x5A,
// plus read data LSB first) or NAK (0xEE) back toward a UART TX.
module uart_cmd_ctrl #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int UART_BPS      = 9600,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_write,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  // Inter-byte gap limit: TIMEOUT_BYTES byte times of 10 bits each.
  localparam logic [31:0] LIMIT = 32'(TIMEOUT_BYTES * 10 * (CLK_FREQ / UART_BPS));

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_CSUM, S_ISSUE, S_WAIT_RSP, S_SEND, S_NAK
  } state_e;

  state_e      state_q, state_d;
  logic        rx_prev_q;
  logic [1:0]  idx_q, idx_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] gap_q, gap_d;
  logic [7:0]  err_q, err_d;
  logic [2:0]  snd_q, snd_d;
  logic        err_inc;
  logic        strobe;

  // A held-high rx_done counts once: only the 0->1 transition is a byte.
  assign strobe = rx_done & ~rx_prev_q;

  // State and datapath registers; reset drops any in-flight frame or response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rx_prev_q <= 1'b0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      csum_q    <= '0;
      gap_q     <= '0;
      err_q     <= '0;
      snd_q     <= '0;
    end else begin
      state_q   <= state_d;
      rx_prev_q <= rx_done;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      csum_q    <= csum_d;
      gap_q     <= gap_d;
      err_q     <= err_d;
      snd_q     <= snd_d;
    end
  end

  // Frame parser, bus/tx sequencing, gap timeout and error counting.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    csum_d  = csum_q;
    gap_d   = gap_q;
    snd_d   = snd_q;
    err_inc = 1'b0;

    case (state_q)
      S_IDLE: begin
        gap_d = '0;
        if (strobe && rx_data == 8'hA5) begin
          state_d = S_CMD;
          csum_d  = '0;
          idx_d   = '0;
        end
      end
      S_CMD, S_ADDR, S_DATA, S_CSUM: begin
        // A strobe in the same cycle as the limit wins over the timeout.
        if (strobe) begin
          gap_d = '0;
          case (state_q)
            S_CMD: begin
              if (rx_data == 8'h01 || rx_data == 8'h02) begin
                wr_d    = (rx_data == 8'h01);
                csum_d  = csum_q ^ rx_data;
                idx_d   = '0;
                state_d = S_ADDR;
              end else begin
                state_d = S_NAK;
                err_inc = 1'b1;
              end
            end
            S_ADDR: begin
              // Bytes arrive LSB first, so shift in from the top.
              addr_d = {rx_data, addr_q[31:8]};
              csum_d = csum_q ^ rx_data;
              idx_d  = idx_q + 2'd1;
              if (idx_q == 2'd3) state_d = wr_q ? S_DATA : S_CSUM;
            end
            S_DATA: begin
              wdata_d = {rx_data, wdata_q[31:8]};
              csum_d  = csum_q ^ rx_data;
              idx_d   = idx_q + 2'd1;
              if (idx_q == 2'd3) state_d = S_CSUM;
            end
            default: begin
              if (rx_data == csum_q) begin
                state_d = S_ISSUE;
              end else begin
                state_d = S_NAK;
                err_inc = 1'b1;
              end
            end
          endcase
        end else begin
          gap_d = gap_q + 32'd1;
          if (gap_d >= LIMIT) begin
            state_d = S_IDLE;
            gap_d   = '0;
            err_inc = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (bus_req_ready) begin
          state_d = wr_q ? S_SEND : S_WAIT_RSP;
          snd_d   = '0;
        end
      end
      S_WAIT_RSP: begin
        if (bus_rsp_valid) begin
          rdata_d = bus_rsp_rdata;
          snd_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          if (wr_q || snd_q == 3'd4) state_d = S_IDLE;
          else                       snd_d   = snd_q + 3'd1;
        end
      end
      S_NAK: begin
        if (tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    err_d = err_q;
    if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  // Response byte select; register-driven so it holds while tx_ready is low.
  always_comb begin
    tx_data = 8'h00;
    if (state_q == S_NAK) begin
      tx_data = 8'hEE;
    end else if (state_q == S_SEND) begin
      case (snd_q)
        3'd1:    tx_data = rdata_q[7:0];
        3'd2:    tx_data = rdata_q[15:8];
        3'd3:    tx_data = rdata_q[23:16];
        3'd4:    tx_data = rdata_q[31:24];
        default: tx_data = 8'h5A;
      endcase
    end
  end

  assign tx_valid      = (state_q == S_SEND) || (state_q == S_NAK);
  assign bus_req_valid = (state_q == S_ISSUE);
  assign bus_req_write = wr_q;
  assign bus_req_addr  = addr_q;
  assign bus_req_wdata = wdata_q;
  assign busy          = (state_q != S_IDLE);
  assign err_cnt       = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: expected bus requests and tx bytes are
// queued as frames are driven and checked by negedge monitors on handshake.
module tb_uart_cmd_ctrl;

  localparam int CLK_FREQ      = 1_000_000;
  localparam int UART_BPS      = 10_000;
  localparam int TIMEOUT_BYTES = 4;
  localparam int LIMIT         = TIMEOUT_BYTES * 10 * (CLK_FREQ / UART_BPS); // 4000

  logic        clk, rst_n;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        bus_req_valid, bus_req_ready, bus_req_write;
  logic [31:0] bus_req_addr, bus_req_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        busy;
  logic [7:0]  err_cnt;

  uart_cmd_ctrl #(
    .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .TIMEOUT_BYTES(TIMEOUT_BYTES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_done(rx_done), .rx_data(rx_data),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_write(bus_req_write), .bus_req_addr(bus_req_addr),
    .bus_req_wdata(bus_req_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .busy(busy), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t       exp_req[$];
  logic [7:0] exp_tx[$];
  req_t       mon_req;
  logic [7:0] mon_tx;
  int         req_cnt = 0;

  // Monitors: compare each handshake against the head of its queue.
  always @(negedge clk) begin
    if (rst_n && bus_req_valid && bus_req_ready) begin
      req_cnt++;
      if (exp_req.size() == 0) check("req_unexpected", 32'd1, 32'd0);
      else begin
        mon_req = exp_req.pop_front();
        check("req_write", 32'(bus_req_write), 32'(mon_req.wr));
        check("req_addr", bus_req_addr, mon_req.addr);
        if (mon_req.wr) check("req_wdata", bus_req_wdata, mon_req.wdata);
      end
    end
    if (rst_n && tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) check("tx_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
      else begin
        mon_tx = exp_tx.pop_front();
        check("tx_byte", 32'(tx_data), 32'(mon_tx));
      end
    end
  end

  // Inputs change 1ns after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    rx_data = b;
    rx_done = 1'b1;
    tick(hold);
    rx_done = 1'b0;
    tick(gap);
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int hold);
    foreach (f[i]) send_byte(f[i], hold, 3);
  endtask

  // Bus responder: accept after `delay` cycles, then answer reads.
  task automatic serve(input int delay, input logic is_rd, input logic [31:0] rd);
    int t = 0;
    while (!bus_req_valid && t < 200) begin tick(); t++; end
    check("req_valid_seen", 32'(bus_req_valid), 32'd1);
    if (!bus_req_valid) return;
    tick(delay);
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
    if (is_rd) begin
      tick(2);
      bus_rsp_valid = 1'b1;
      bus_rsp_rdata = rd;
      tick();
      bus_rsp_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 20000) begin tick(); t++; end
    tick(2);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_txq"}, 32'(exp_tx.size()), 32'd0);
    check({tag, "_reqq"}, 32'(exp_req.size()), 32'd0);
  endtask

  task automatic push_tx_rd(input logic [31:0] rd);
    exp_tx.push_back(8'h5A);
    exp_tx.push_back(rd[7:0]);
    exp_tx.push_back(rd[15:8]);
    exp_tx.push_back(rd[23:16]);
    exp_tx.push_back(rd[31:24]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] fr[$];
  int         rc;
  int         t;

  initial begin
    rst_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
    tx_ready = 1'b1;
    tick(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_valid", 32'(bus_req_valid), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_addr", bus_req_addr, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Write frame.
    exp_req.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF});
    exp_tx.push_back(8'h5A);
    fr = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33};
    send_frame(fr, 1);
    serve(0, 1'b0, '0);
    wait_idle("wr");
    check("wr_err", 32'(err_cnt), 32'd0);

    // Read frame, ready after 3 cycles, tx stalled mid-stream.
    exp_req.push_back('{1'b0, 32'h0000_0020, 32'h0});
    push_tx_rd(32'h1234_5678);
    fr = '{8'hA5, 8'h02, 8'h20, 8'h00, 8'h00, 8'h00, 8'h22};
    send_frame(fr, 1);
    serve(3, 1'b1, 32'h1234_5678);
    t = 0;
    while (!(tx_valid && tx_data == 8'h56) && t < 200) begin tick(); t++; end
    check("rd_mid_byte", 32'(tx_data), 32'h56);
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rd_stall_data", 32'(tx_data), 32'h56);
      check("rd_stall_valid", 32'(tx_valid), 32'd1);
    end
    tx_ready = 1'b1;
    wait_idle("rd");

    // Bad checksum.
    rc = req_cnt;
    exp_tx.push_back(8'hEE);
    fr = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h34};
    send_frame(fr, 1);
    tick(20);
    check("csum_no_req", 32'(req_cnt - rc), 32'd0);
    wait_idle("csum");
    check("csum_err", 32'(err_cnt), 32'd1);

    // Unknown command, then non-A5 bytes while idle.
    exp_tx.push_back(8'hEE);
    fr = '{8'hA5, 8'h07};
    send_frame(fr, 1);
    wait_idle("cmd");
    fr = '{8'h00, 8'h5A, 8'h33};
    send_frame(fr, 1);
    check("trail_busy", 32'(busy), 32'd0);
    check("cmd_err", 32'(err_cnt), 32'd2);

    // Inter-byte timeout.
    fr = '{8'hA5, 8'h01, 8'h10};
    send_frame(fr, 1);
    tick(LIMIT - 100);
    check("to_before_busy", 32'(busy), 32'd1);
    tick(200);
    check("to_after_busy", 32'(busy), 32'd0);
    check("to_err", 32'(err_cnt), 32'd3);
    check("to_no_tx", 32'(tx_valid), 32'd0);
    exp_req.push_back('{1'b0, 32'h0000_0030, 32'h0});
    push_tx_rd(32'hCAFE_F00D);
    fr = '{8'hA5, 8'h02, 8'h30, 8'h00, 8'h00, 8'h00, 8'h32};
    send_frame(fr, 1);
    serve(1, 1'b1, 32'hCAFE_F00D);
    wait_idle("to_rd");

    // rx_done held high for 2600 cycles per byte.
    exp_req.push_back('{1'b0, 32'h0000_0020, 32'h0});
    push_tx_rd(32'hAABB_CCDD);
    fr = '{8'hA5, 8'h02, 8'h20, 8'h00, 8'h00, 8'h00, 8'h22};
    send_frame(fr, 2600);
    serve(1, 1'b1, 32'hAABB_CCDD);
    wait_idle("hold");
    check("hold_err", 32'(err_cnt), 32'd3);

    // Reset while in ISSUE.
    fr = '{8'hA5, 8'h01, 8'h44, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h41};
    send_frame(fr, 1);
    check("pre_rst_valid", 32'(bus_req_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus_req_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err", 32'(err_cnt), 32'd0);
    check("mid_rst_addr", bus_req_addr, 32'd0);
    check("mid_rst_wdata", bus_req_wdata, 32'd0);
    check("mid_rst_write", 32'(bus_req_write), 32'd0);
    check("mid_rst_tx", 32'({tx_valid, tx_data}), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    exp_req.push_back('{1'b1, 32'h0000_0044, 32'h0102_0304});
    exp_tx.push_back(8'h5A);
    send_frame(fr, 1);
    serve(2, 1'b0, '0);
    wait_idle("post_rst");
    check("post_rst_err", 32'(err_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
